mem_wait_ctrl: RTL and testbench
================================

Name: mem_wait_ctrl

Overview:
Memory-side bus controller between the Cpu request port and a synchronous single-port RAM such as TestRam. It latches each CPU read or write request and inserts a programmable number of wait states. It then performs the RAM access and returns a one-cycle data_ready pulse, which feeds the Cpu enable/handshake logic. Accesses outside the populated RAM window are decoded as open bus.

Parameters:
ADDR_W, 24, CPU physical address width
DATA_W, 8, data bus width
RAM_ADDR_W, 16, populated RAM address width; RAM window is addr[ADDR_W-1:RAM_ADDR_W]==0
WAIT_STATES, 1, extra wait cycles per access, legal range 0..15
WAIT_CNT_W, 4, wait counter width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, asynchronous assert, active-low
req_rdwr  in  1  CPU access request, held high until data_ready is seen
which_rdwr  in  1  access type, WH_READ=0 / WH_WRITE=1
addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data returned to CPU, valid when data_ready=1
data_ready  out  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE
ram_we  out  1  RAM write strobe
ram_addr  out  RAM_ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr is presented

Behaviour:
- Reset (rst=0, async): state=IDLE; data_ready=0; ram_we=0; busy=0; ram_addr=0; ram_wdata=0; cpu_rdata=0; open-bus latch=0; wait counter=0.
- FSM states:
  - IDLE: if req_rdwr=1, latch addr, which_rdwr and cpu_wdata, and compute in_range. Go to WAIT if WAIT_STATES>0, else ACCESS. Load counter with WAIT_STATES-1.
  - WAIT: decrement counter; when counter==0, go to ACCESS.
  - ACCESS: drive ram_addr from the latched address.
    - Write, in range: ram_we=1 for exactly this cycle.
    - Write, out of range: ram_we stays 0.
    - Next state is READ_CAP for reads, DONE for writes.
  - READ_CAP: capture ram_rdata into cpu_rdata and the open-bus latch if in range; otherwise cpu_rdata=open-bus latch. Go to DONE.
  - DONE: data_ready=1 for exactly one cycle; go to IDLE.
- Latency, counted from the cycle req_rdwr is sampled in IDLE (cycle 0) to the data_ready cycle:
  - read: WAIT_STATES+3
  - write: WAIT_STATES+2
- Request fields are latched at acceptance. Changes to addr, which_rdwr or cpu_wdata while busy are ignored.
- Handshake: the CPU drops req_rdwr or presents a new request in the cycle after data_ready. req_rdwr high in IDLE is always treated as a new request. Minimum turnaround is 1 idle cycle between accesses.
- Abort: req_rdwr=0 observed in WAIT returns the FSM to IDLE with no RAM write and no data_ready. Once in ACCESS or later, the access completes and data_ready is still pulsed.
- Open bus: the latch holds the last successfully read in-range byte. Writes do not update it.
- cpu_rdata holds its value between accesses; it changes only in READ_CAP.
- ram_addr = latched addr[RAM_ADDR_W-1:0], truncated regardless of range.
- Reset mid-operation: immediate return to the reset state. Any in-flight write is dropped, and ram_we deasserts asynchronously.
- ram_we, data_ready and busy are registered outputs (no combinational path from inputs).

Decomposition:
- Shared package/include (alongside the cpu_enums defines):
  - state encodings ST_IDLE, ST_WAIT, ST_ACCESS, ST_READ_CAP, ST_DONE (3-bit)
  - WH_READ/WH_WRITE values, matching the existing CPU which_rdwr enum
- One natural sub-module, mem_addr_decode: combinational in_range from addr and RAM_ADDR_W. Reusable for future ROM/IO windows.

Test Plan:
- WAIT_STATES=1: read of in-range addr 0x000010 with RAM[0x0010]=0xA5 -> data_ready on cycle 4, cpu_rdata=0xA5, busy high cycles 1-4.
- Write 0x3C to 0x001234 -> ram_we high for exactly one cycle with ram_addr=0x1234, ram_wdata=0x3C; data_ready on cycle 3. A following read returns 0x3C.
- Out-of-range write to 0x010000 -> ram_we never asserts. A read of 0x020000 after an in-range read of 0x5A returns 0x5A (open bus) with normal read latency.
- req_rdwr dropped during WAIT (WAIT_STATES=4, drop at cycle 2) -> no ram_we, no data_ready, busy=0 next cycle, next request accepted normally.
- rst pulsed low during ACCESS of a write -> ram_we, data_ready and busy go 0 asynchronously; state is IDLE after release. A following read gets correct data.
- WAIT_STATES=0: back-to-back read/write/read stream -> read latency 3, write latency 2, one idle cycle between data_ready and the next acceptance.

Source files
------------

// File: rtl/mem_wait_ctrl_pkg.sv
// Shared types for the memory-side wait-state controller: FSM state encodings
// and the CPU access-type values carried on which_rdwr.
package mem_wait_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_READ_CAP = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Must match the CPU's which_rdwr encoding.
  localparam logic WH_READ  = 1'b0;
  localparam logic WH_WRITE = 1'b1;

  function automatic logic is_write(input logic which);
    return which == WH_WRITE;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Address window decoder: flags addresses whose bits above the populated RAM
// width are all zero. Kept separate so ROM/IO windows can reuse it.
module mem_addr_decode #(
  parameter int ADDR_W     = 24,
  parameter int RAM_ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  // Shifting by the full width yields zero, so a window covering the whole
  // address space decodes as always in range.
  assign in_range = ((addr >> RAM_ADDR_W) == '0);

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory-side bus controller: latches a CPU request, inserts WAIT_STATES wait
// cycles, performs the RAM access and returns a one-cycle data_ready pulse.
module mem_wait_ctrl
  import mem_wait_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 8,
  parameter int RAM_ADDR_W  = 16,
  parameter int WAIT_STATES = 1,
  parameter int WAIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rdwr,
  input  logic                  which_rdwr,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
  logic                  accept;
  logic                  addr_in_range;
  logic                  lat_write;
  logic                  lat_in_range;
  logic                  we_nxt;
  logic [DATA_W-1:0]     open_bus;

  mem_addr_decode #(
    .ADDR_W    (ADDR_W),
    .RAM_ADDR_W(RAM_ADDR_W)
  ) u_decode (
    .addr    (addr),
    .in_range(addr_in_range)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Dropping the request while still waiting abandons the access; once the
  // RAM cycle has started the transfer always runs to completion.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_rdwr) begin
          accept       = 1'b1;
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (!req_rdwr) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == '0) begin
          state_nxt = ST_ACCESS;
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      ST_ACCESS:   state_nxt = lat_write ? ST_DONE : ST_READ_CAP;
      ST_READ_CAP: state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // With no wait states ACCESS follows acceptance directly, so the strobe
  // must be decided from the live request rather than the latched copy.
  always_comb begin
    we_nxt = 1'b0;
    if (state_nxt == ST_ACCESS) begin
      if (accept) begin
        we_nxt = is_write(which_rdwr) && addr_in_range;
      end else begin
        we_nxt = lat_write && lat_in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      data_ready <= 1'b0;
      ram_we     <= 1'b0;
    end else begin
      busy       <= (state_nxt != ST_IDLE);
      data_ready <= (state_nxt == ST_DONE);
      ram_we     <= we_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_write    <= 1'b0;
      lat_in_range <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else if (accept) begin
      lat_write    <= is_write(which_rdwr);
      lat_in_range <= addr_in_range;
      ram_addr     <= addr[RAM_ADDR_W-1:0];
      ram_wdata    <= cpu_wdata;
    end
  end

  // Out-of-window reads return the last byte actually read from RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
      open_bus  <= '0;
    end else if (state == ST_READ_CAP) begin
      if (lat_in_range) begin
        cpu_rdata <= ram_rdata;
        open_bus  <= ram_rdata;
      end else begin
        cpu_rdata <= open_bus;
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: three instances with 0, 1 and 4 wait states, each
// on its own RAM model, driven by directed and random CPU accesses.
module tb_mem_wait_ctrl;

  logic        clk;
  logic        rst        [3];
  logic        req_rdwr   [3];
  logic        which_rdwr [3];
  logic [23:0] addr       [3];
  logic [7:0]  cpu_wdata  [3];
  logic [7:0]  cpu_rdata  [3];
  logic        data_ready [3];
  logic        busy       [3];
  logic        ram_we     [3];
  logic [15:0] ram_addr   [3];
  logic [7:0]  ram_wdata  [3];
  logic [7:0]  ram_rdata  [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [int];
  logic [7:0] open_bus  [3];
  logic [7:0] last_rd   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 1 : 4);
    mem_wait_ctrl #(
      .ADDR_W(24), .DATA_W(8), .RAM_ADDR_W(16), .WAIT_STATES(WSG), .WAIT_CNT_W(4)
    ) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_rdwr  (req_rdwr[g]),
      .which_rdwr(which_rdwr[g]),
      .addr      (addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_rdata (cpu_rdata[g]),
      .data_ready(data_ready[g]),
      .busy      (busy[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : ((u == 1) ? 1 : 4);
  endfunction

  function automatic logic [7:0] init_byte(input int k, input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'(k * 37 + 11);
  endfunction

  // Synchronous RAM: read data appears one cycle after the address.
  logic [7:0] ram_mem [3][65536];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < 65536; a++)
          ram_mem[k][a] = init_byte(k, 16'(a));
      ram_loaded = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        ram_rdata[k] <= ram_mem[k][ram_addr[k]];
        if (ram_we[k]) ram_mem[k][ram_addr[k]] = ram_wdata[k];
      end
    end
  end

  function automatic logic [7:0] model_read(input int u, input logic [15:0] a);
    int key;
    key = u * 65536 + int'(a);
    return model_mem.exists(key) ? model_mem[key] : init_byte(u, a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access on instance u, starting in an idle cycle. The request
  // fields are scrambled while busy to show they were latched at acceptance.
  task automatic apply_stimulus(input int u, input bit wr, input logic [23:0] a, input logic [7:0] d);
    int n, we_pulses, we_cycle, busy_bad, exp_lat;
    bit seen, in_rng;
    logic [7:0] exp_rd;
    in_rng  = (a[23:16] == 8'h00);
    exp_lat = ws_of(u) + (wr ? 2 : 3);
    req_rdwr[u] = 1'b1; which_rdwr[u] = wr; addr[u] = a; cpu_wdata[u] = d;
    step();
    n = 1; we_pulses = 0; we_cycle = -1; busy_bad = 0; seen = 1'b0;
    while (n <= 40 && !seen) begin
      which_rdwr[u] = 1'($urandom); addr[u] = 24'($urandom); cpu_wdata[u] = 8'($urandom);
      if (busy[u] !== 1'b1) busy_bad++;
      if (ram_we[u] === 1'b1) begin
        we_pulses++;
        we_cycle = n;
        check_output($sformatf("u%0d we_addr", u), 32'(ram_addr[u]), 32'(a[15:0]));
        check_output($sformatf("u%0d we_data", u), 32'(ram_wdata[u]), 32'(d));
      end
      if (data_ready[u] === 1'b1) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    check_output($sformatf("u%0d latency", u), seen ? n : 999, exp_lat);
    check_output($sformatf("u%0d busy_held", u), busy_bad, 0);
    check_output($sformatf("u%0d we_count", u), we_pulses, (wr && in_rng) ? 1 : 0);
    if (wr && in_rng)
      check_output($sformatf("u%0d we_cycle", u), we_cycle, ws_of(u) + 1);
    if (!wr) begin
      exp_rd = in_rng ? model_read(u, a[15:0]) : open_bus[u];
      check_output($sformatf("u%0d rdata", u), 32'(cpu_rdata[u]), 32'(exp_rd));
      if (in_rng) open_bus[u] = exp_rd;
      last_rd[u] = exp_rd;
    end else begin
      check_output($sformatf("u%0d rdata_hold", u), 32'(cpu_rdata[u]), 32'(last_rd[u]));
      if (in_rng) model_mem[u * 65536 + int'(a[15:0])] = d;
    end
    step();
    req_rdwr[u] = 1'b0;
    check_output($sformatf("u%0d ready_pulse", u), 32'(data_ready[u]), 0);
    check_output($sformatf("u%0d idle_busy", u), 32'(busy[u]), 0);
  endtask

  bit          r_wr;
  logic [23:0] r_addr;
  int          n_wait;
  int          bad_we;
  int          bad_rdy;

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b0; req_rdwr[u] = 1'b0; which_rdwr[u] = 1'b0;
      addr[u] = '0; cpu_wdata[u] = '0; open_bus[u] = '0; last_rd[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check_output($sformatf("u%0d rst_ready", u), 32'(data_ready[u]), 0);
      check_output($sformatf("u%0d rst_busy", u), 32'(busy[u]), 0);
      check_output($sformatf("u%0d rst_we", u), 32'(ram_we[u]), 0);
      check_output($sformatf("u%0d rst_raddr", u), 32'(ram_addr[u]), 0);
      check_output($sformatf("u%0d rst_rwdata", u), 32'(ram_wdata[u]), 0);
      check_output($sformatf("u%0d rst_rdata", u), 32'(cpu_rdata[u]), 0);
      rst[u] = 1'b1;
    end
    step();

    $display("[TB] directed accesses, one wait state");
    apply_stimulus(1, 1'b1, 24'h000010, 8'hA5);
    apply_stimulus(1, 1'b0, 24'h000010, 8'h00);
    apply_stimulus(1, 1'b1, 24'h001234, 8'h3C);
    apply_stimulus(1, 1'b0, 24'h001234, 8'h00);
    apply_stimulus(1, 1'b1, 24'h010000, 8'h77);
    apply_stimulus(1, 1'b0, 24'h000000, 8'h00);
    apply_stimulus(1, 1'b1, 24'h000020, 8'h5A);
    apply_stimulus(1, 1'b0, 24'h000020, 8'h00);
    apply_stimulus(1, 1'b0, 24'h020000, 8'h00);

    $display("[TB] abort during wait states");
    req_rdwr[2] = 1'b1; which_rdwr[2] = 1'b1; addr[2] = 24'h000040; cpu_wdata[2] = 8'hEE;
    step();
    step();
    req_rdwr[2] = 1'b0;
    step();
    check_output("u2 abort_busy", 32'(busy[2]), 0);
    bad_we = 0; bad_rdy = 0;
    repeat (8) begin
      if (ram_we[2] !== 1'b0) bad_we++;
      if (data_ready[2] !== 1'b0) bad_rdy++;
      step();
    end
    check_output("u2 abort_we", bad_we, 0);
    check_output("u2 abort_ready", bad_rdy, 0);
    apply_stimulus(2, 1'b0, 24'h000040, 8'h00);

    $display("[TB] reset during a write access");
    req_rdwr[1] = 1'b1; which_rdwr[1] = 1'b1; addr[1] = 24'h000050; cpu_wdata[1] = 8'h99;
    step();
    n_wait = 1;
    while (ram_we[1] !== 1'b1 && n_wait < 20) begin
      step();
      n_wait++;
    end
    check_output("u1 rst_reach_access", 32'(ram_we[1]), 1);
    rst[1] = 1'b0;
    #1;
    check_output("u1 async_we", 32'(ram_we[1]), 0);
    check_output("u1 async_busy", 32'(busy[1]), 0);
    check_output("u1 async_ready", 32'(data_ready[1]), 0);
    check_output("u1 async_rdata", 32'(cpu_rdata[1]), 0);
    req_rdwr[1] = 1'b0;
    open_bus[1] = 8'h00;
    last_rd[1]  = 8'h00;
    #1;
    rst[1] = 1'b1;
    step();
    check_output("u1 post_rst_busy", 32'(busy[1]), 0);
    apply_stimulus(1, 1'b0, 24'h000050, 8'h00);
    apply_stimulus(1, 1'b0, 24'h030000, 8'h00);

    $display("[TB] back-to-back stream, no wait states");
    apply_stimulus(0, 1'b0, 24'h000100, 8'h00);
    apply_stimulus(0, 1'b1, 24'h000100, 8'hC3);
    apply_stimulus(0, 1'b0, 24'h000100, 8'h00);

    $display("[TB] random accesses");
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 25; i++) begin
        r_wr = 1'($urandom);
        r_addr[15:0]  = 16'($urandom_range(0, 31));
        r_addr[23:16] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        apply_stimulus(u, r_wr, r_addr, 8'($urandom));
        repeat ($urandom_range(0, 2)) step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
